// File: rtl/alu_issue_unit_if.sv
// Bundle of the instruction handshake, ALU operand/result bus, flags and debug read port.
// master = instruction source / ALU / debug side, slave = alu_issue_unit.
interface alu_issue_unit_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_instr;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_opcode;
  logic [3:0]       alu_shift;
  logic             alu_execute;
  logic [WIDTH-1:0] alu_result;
  logic [3:0]       alu_flags;
  logic [3:0]       flags;
  logic             done;
  logic [3:0]       dbg_addr;
  logic [WIDTH-1:0] dbg_rdata;

  modport master (
    output in_valid, in_instr, alu_result, alu_flags, dbg_addr,
    input  in_ready, alu_a, alu_b, alu_opcode, alu_shift, alu_execute, flags, done, dbg_rdata
  );

  modport slave (
    input  in_valid, in_instr, alu_result, alu_flags, dbg_addr,
    output in_ready, alu_a, alu_b, alu_opcode, alu_shift, alu_execute, flags, done, dbg_rdata
  );
endinterface

// File: rtl/alu_issue_unit.sv
// Operand fetch, issue to the external ALU and writeback into a 16-entry register file.
// state | meaning
// IDLE  | in_ready high; accept instruction, read rs/rt
// EXEC  | alu_execute high; capture ALU result and flags
// WB    | done high; write rd (unless CMP or r0), update flags
module alu_issue_unit #(
  parameter int         WIDTH  = 16,
  parameter logic [3:0] SUB_OP = 4'd1,
  parameter logic [3:0] CMP_OP = 4'd15
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_issue_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] rf_q [16];
  logic [WIDTH-1:0] alu_a_q, alu_b_q, res_q;
  logic [3:0]       alu_opcode_q, alu_shift_q, rd_q, flg_q, flags_q;
  logic             cmp_q;

  logic [3:0]       op_d, rs_d, rt_d;
  logic             cmp_d;

  assign op_d  = bus.in_instr[15:12];
  assign rs_d  = bus.in_instr[7:4];
  assign rt_d  = bus.in_instr[3:0];
  assign cmp_d = (op_d == CMP_OP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_opcode_q <= '0;
      alu_shift_q  <= '0;
      rd_q         <= '0;
      cmp_q        <= 1'b0;
      res_q        <= '0;
      flg_q        <= '0;
      flags_q      <= '0;
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            alu_a_q      <= rf_q[rs_d];
            alu_b_q      <= rf_q[rt_d];
            alu_shift_q  <= rt_d;
            rd_q         <= bus.in_instr[11:8];
            cmp_q        <= cmp_d;
            alu_opcode_q <= cmp_d ? SUB_OP : op_d;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          res_q   <= bus.alu_result;
          flg_q   <= bus.alu_flags;
          state_q <= WB;
        end
        WB: begin
          // r0 is never written, so it stays at its reset value of zero
          if (!cmp_q && rd_q != 4'd0) rf_q[rd_q] <= res_q;
          flags_q <= flg_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.alu_execute = (state_q == EXEC);
  assign bus.done        = (state_q == WB);
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_opcode  = alu_opcode_q;
  assign bus.alu_shift   = alu_shift_q;
  assign bus.flags       = flags_q;
  assign bus.dbg_rdata   = (bus.dbg_addr == 4'd0) ? '0 : rf_q[bus.dbg_addr];

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a small behavioural ALU on the result side.
module tb_alu_issue_unit;
  logic clk;
  logic rst_n;
  int   n_chk  = 0;
  int   n_pass = 0;
  logic [15:0] exp_rf [16];

  alu_issue_unit_if #(.WIDTH(16)) bus ();

  alu_issue_unit #(.WIDTH(16), .SUB_OP(4'd1), .CMP_OP(4'd15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model: 0 add, 1 sub, 8 load shift field as immediate, others xor.
  // flags = {overflow, carry/borrow, negative, zero}
  logic [16:0] t;
  logic        ovf;
  always_comb begin
    t   = '0;
    ovf = 1'b0;
    case (bus.alu_opcode)
      4'd0: begin
        t   = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        ovf = (bus.alu_a[15] == bus.alu_b[15]) && (t[15] != bus.alu_a[15]);
      end
      4'd1: begin
        t   = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
        ovf = (bus.alu_a[15] != bus.alu_b[15]) && (t[15] != bus.alu_a[15]);
      end
      4'd8:    t = {13'd0, bus.alu_shift};
      default: t = {1'b0, bus.alu_a ^ bus.alu_b};
    endcase
    bus.alu_result = t[15:0];
    bus.alu_flags  = {ovf, t[16], t[15], (t[15:0] == 16'd0)};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 16; i++) begin
      bus.dbg_addr = 4'(i);
      #1;
      check($sformatf("%s_r%0d", tag, i), {16'd0, bus.dbg_rdata}, {16'd0, exp_rf[i]});
    end
  endtask

  // Issue one instruction and follow it through EXEC and WB.
  task automatic issue(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                       input logic [3:0] rt, input logic [15:0] ea, input logic [15:0] eb,
                       input logic [3:0] ef);
    @(negedge clk);
    check("rdy_pre", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.in_instr = {op, rd, rs, rt};
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_instr = 16'hFFFF;
    check("exe_exec",  {31'd0, bus.alu_execute}, 32'd1);
    check("done_exec", {31'd0, bus.done}, 32'd0);
    check("rdy_exec",  {31'd0, bus.in_ready}, 32'd0);
    check("alu_a",     {16'd0, bus.alu_a}, {16'd0, ea});
    check("alu_b",     {16'd0, bus.alu_b}, {16'd0, eb});
    check("alu_op",    {28'd0, bus.alu_opcode}, {28'd0, (op == 4'd15) ? 4'd1 : op});
    check("alu_shift", {28'd0, bus.alu_shift}, {28'd0, rt});
    @(negedge clk);
    check("exe_wb",  {31'd0, bus.alu_execute}, 32'd0);
    check("done_wb", {31'd0, bus.done}, 32'd1);
    check("rdy_wb",  {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    check("done_post", {31'd0, bus.done}, 32'd0);
    check("rdy_post",  {31'd0, bus.in_ready}, 32'd1);
    check("flags",     {28'd0, bus.flags}, {28'd0, ef});
  endtask

  initial begin
    int dn;
    for (int i = 0; i < 16; i++) exp_rf[i] = 16'd0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_instr = 16'h0312;
    bus.dbg_addr = 4'd0;

    // reset with in_valid held high: nothing may be accepted
    repeat (3) @(negedge clk);
    check("rst_exe",   {31'd0, bus.alu_execute}, 32'd0);
    check("rst_done",  {31'd0, bus.done}, 32'd0);
    check("rst_rdy",   {31'd0, bus.in_ready}, 32'd1);
    check("rst_a",     {16'd0, bus.alu_a}, 32'd0);
    check("rst_b",     {16'd0, bus.alu_b}, 32'd0);
    check("rst_op",    {28'd0, bus.alu_opcode}, 32'd0);
    check("rst_shift", {28'd0, bus.alu_shift}, 32'd0);
    check("rst_flags", {28'd0, bus.flags}, 32'd0);
    check_regs("rst");
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    @(negedge clk);
    check("rel_rdy", {31'd0, bus.in_ready}, 32'd1);
    check("rel_exe", {31'd0, bus.alu_execute}, 32'd0);

    // preload R1=5, R2=7, then R3 = R1 + R2
    issue(4'd8, 4'd1, 4'd0, 4'd5, 16'd0, 16'd0, 4'b0000);
    exp_rf[1] = 16'h0005;
    issue(4'd8, 4'd2, 4'd0, 4'd7, 16'd0, 16'd0, 4'b0000);
    exp_rf[2] = 16'h0007;
    issue(4'd0, 4'd3, 4'd1, 4'd2, 16'h0005, 16'h0007, 4'b0000);
    exp_rf[3] = 16'h000C;
    check_regs("add");

    // CMP R1,R1: subtract, zero flag, no write to R9
    issue(4'd15, 4'd9, 4'd1, 4'd1, 16'h0005, 16'h0005, 4'b0001);
    check_regs("cmp");

    // write to r0 discarded, flags still updated
    issue(4'd0, 4'd0, 4'd1, 4'd2, 16'h0005, 16'h0007, 4'b0000);
    check_regs("r0");

    // back-to-back dependent pair with in_valid held high
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_instr = {4'd0, 4'd4, 4'd1, 4'd2};
    @(negedge clk);
    check("b2b_exe1", {31'd0, bus.alu_execute}, 32'd1);
    check("b2b_rdy1", {31'd0, bus.in_ready}, 32'd0);
    bus.in_instr = {4'd0, 4'd5, 4'd4, 4'd4};
    @(negedge clk);
    check("b2b_done1", {31'd0, bus.done}, 32'd1);
    check("b2b_rdy2",  {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    check("b2b_idle_rdy",  {31'd0, bus.in_ready}, 32'd1);
    check("b2b_idle_done", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    check("b2b_exe2", {31'd0, bus.alu_execute}, 32'd1);
    check("b2b_a2",   {16'd0, bus.alu_a}, 32'h000C);
    check("b2b_b2",   {16'd0, bus.alu_b}, 32'h000C);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("b2b_done2", {31'd0, bus.done}, 32'd1);
    @(negedge clk);
    check("b2b_rdy3", {31'd0, bus.in_ready}, 32'd1);
    exp_rf[4] = 16'h000C;
    exp_rf[5] = 16'h0018;
    check_regs("b2b");

    // negative result: R7 = 5 - 7 sets borrow and negative
    issue(4'd1, 4'd7, 4'd1, 4'd2, 16'h0005, 16'h0007, 4'b0110);
    exp_rf[7] = 16'hFFFE;
    check_regs("sub");

    // reset during EXEC of a write to R6
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_instr = {4'd8, 4'd6, 4'd0, 4'd9};
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("abort_exe", {31'd0, bus.alu_execute}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_exe0",  {31'd0, bus.alu_execute}, 32'd0);
    check("abort_rdy",   {31'd0, bus.in_ready}, 32'd1);
    check("abort_flags", {28'd0, bus.flags}, 32'd0);
    check("abort_a",     {16'd0, bus.alu_a}, 32'd0);
    dn = 0;
    repeat (2) begin
      @(negedge clk);
      dn += int'(bus.done);
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      dn += int'(bus.done);
    end
    check("abort_no_done", dn, 32'd0);
    for (int i = 0; i < 16; i++) exp_rf[i] = 16'd0;
    check_regs("abort");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/alu_issue_unit.md
# alu_issue_unit

Operand-fetch, issue and writeback stage that sits directly upstream and downstream of the 16-bit ALU. It accepts one instruction word at a time over a valid/ready handshake and reads two source operands from an internal 16x16 register file. It drives the ALU's operand, opcode, shift and execute inputs, then captures the ALU result and flags and writes them back to the register file and the architectural flag register.

## Interface
- `WIDTH`, 16, data width; must match the ALU `len`
- `SUB_OP`, 4'd1, ALU opcode that selects subtraction; used to implement CMP
- `CMP_OP`, 4'd15, instruction opcode meaning compare: subtract, update flags, no register write

- `clk` input 1: single clock; all state changes on its rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `in_valid` input 1: instruction word present
- `in_instr` input 16: [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt / shift amount
- `in_ready` output 1: unit can accept an instruction; high only in IDLE
- `alu_a` output WIDTH: to ALU `r2`; register value of rs
- `alu_b` output WIDTH: to ALU `r3`; register value of rt
- `alu_opcode` output 4: to ALU `opcode`
- `alu_shift` output 4: to ALU `shift_bits`; equals `in_instr[3:0]`
- `alu_execute` output 1: to ALU `execute`; high for exactly the EXEC cycle
- `alu_result` input WIDTH: from ALU `r1`; combinational
- `alu_flags` input 4: from ALU `flags`; combinational
- `flags` output 4: architectural flag register
- `done` output 1: one-cycle pulse in WB
- `dbg_addr` input 4: debug read address
- `dbg_rdata` output WIDTH: combinational register file read of `dbg_addr`; r0 reads 0

## Operation
- Register file: 16 x WIDTH. r0 always reads 0, and writes to r0 are discarded. All entries clear to 0 on reset.
- State machine: IDLE -> EXEC -> WB -> IDLE.
- IDLE: `in_ready`=1. On `in_valid & in_ready`:
  - latch `alu_a` <= R[rs], `alu_b` <= R[rt], `alu_shift` <= instr[3:0]
  - latch rd and a cmp bit = (opcode == CMP_OP)
  - latch `alu_opcode` <= SUB_OP if cmp, else opcode
  - go to EXEC
  - With `in_valid` low the unit stays in IDLE and all registers hold.
- EXEC: `alu_execute`=1, `in_ready`=0. At the closing edge, capture `alu_result` into res_q and `alu_flags` into flg_q. Go to WB.
- WB: `done`=1.
  - If not cmp and rd != 0: R[rd] <= res_q.
  - `flags` <= flg_q, always, including CMP and rd=0.
  - Go to IDLE.
- `alu_a`, `alu_b`, `alu_opcode` and `alu_shift` hold their last issued values outside EXEC. The ALU ignores them because `alu_execute`=0.
- Operands are read in IDLE, after any prior WB write has completed. A dependent back-to-back instruction therefore sees the new value, and no bypass is needed.
- `in_instr` is sampled only on the accepting edge. Changes to it during EXEC or WB are ignored.

## Timing
- Reset values:
  - `in_ready`=1, because state resets to IDLE.
  - `alu_a`=`alu_b`=0, `alu_opcode`=0, `alu_shift`=0.
  - `alu_execute`=0, `done`=0, `flags`=0.
  - All registers are 0.
- Latency: accept at edge 0, EXEC during cycle 1, WB during cycle 2. The register and flag update is visible from cycle 3.
- Throughput: one instruction every 3 cycles. The earliest next accept is the edge ending the cycle after WB.
- `done` and `alu_execute` are decoded from the state register, so they are glitch-free and never high in the same cycle.
- Reset asserted mid-operation aborts the instruction. No writeback occurs, and everything returns to reset values immediately.
- `dbg_rdata` reflects a WB write starting the cycle after WB.

## Test plan
- Reset with `in_valid`=1 held -> no accept while `rst_n`=0. All outputs and `dbg_rdata` for addresses 0..15 read 0. `in_ready`=1 after release.
- Preload through ALU ops, then issue ADD (opcode 0) with rd=3, rs=1 (0x0005), rt=2 (0x0007) -> `alu_execute` high exactly 1 cycle, `done` on the 2nd cycle after accept, R3=0x000C, `flags` equal the ALU value for that result.
- CMP_OP with rs=rt=0x0005 -> `alu_opcode`=SUB_OP during EXEC, zero flag set in `flags`, all registers unchanged.
- Write to rd=0 with a nonzero result -> `dbg_rdata`(0)=0 and `flags` updated.
- Back-to-back dependent pair R4=R1+R2, then R5=R4+R4 with `in_valid` held high -> second accept occurs the cycle after the first `done`, R5=0x0018. `in_ready` is low for exactly 2 cycles per instruction.
- `rst_n` pulsed low during EXEC of a write to R6 -> R6 stays 0, `done` never pulses, `flags`=0.
